// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction memory read bus and decode-side valid/ready bus of the fetch stage
interface if_fetch_if #(
  parameter int ADDR_W = 17,
  parameter int INSN_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;
  logic              id_valid;
  logic [INSN_W-1:0] id_insn;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;
  modport master (
    output imem_req, imem_addr, id_valid, id_insn, id_pc,
    input  imem_ack, imem_rdata, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_insn, id_pc,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: fetch front end with req/ack imem reads, 2-entry FIFO to decode, flush; IF_FETCH_STALL_CNT_EN adds stall_cnt
module if_fetch #(
  parameter int ADDR_W = 17,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_adv,
  input  logic              flush,
  if_fetch_if.master        bus
`ifdef IF_FETCH_STALL_CNT_EN
  , output logic [15:0]     stall_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;
  state_t            state, state_nx;
  logic [1:0]        count;
  logic              rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] drop_addr;
  logic [INSN_W-1:0] insn_q [2];
  logic [ADDR_W-1:0] pc_q [2];
  logic              fire, push, pop;
  assign bus.id_valid = count != 2'd0;
  assign bus.id_insn  = insn_q[rd_ptr];
  assign bus.id_pc    = pc_q[rd_ptr];
  // request generation, handshake qualification and next state
  always_comb begin
    bus.imem_req  = (state == RUN && count != 2'd2) || state == DROP;
    bus.imem_addr = state == DROP ? drop_addr : pc_i;
    fire          = bus.imem_req && bus.imem_ack;
    push          = state == RUN && fire && !flush;
    pop           = bus.id_valid && bus.id_ready && !flush;
    pc_adv        = push;
    state_nx      = state == IDLE ? RUN :
                    state == RUN  ? ((flush && bus.imem_req && !bus.imem_ack) ? DROP : RUN) :
                    (bus.imem_ack ? RUN : DROP);
  end
  // state, orphaned-request address and FIFO occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      drop_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == RUN && flush && bus.imem_req && !bus.imem_ack) drop_addr <= pc_i;
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) rd_ptr <= ~rd_ptr;
      end
    end
  end
  // FIFO storage; contents are qualified by count so need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      insn_q[wr_ptr] <= bus.imem_rdata;
      pc_q[wr_ptr]   <= pc_i;
    end
  end
`ifdef IF_FETCH_STALL_CNT_EN
  // saturating count of cycles where decode is ready but has nothing to take
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (state != IDLE && bus.id_ready && !bus.id_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: scoreboard bench for if_fetch with a pc model and a variable-latency memory model
module tb_if_fetch;
  localparam int ADDR_W = 17;
  localparam int INSN_W = 32;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, pc_adv;
  logic [ADDR_W-1:0] pc_i = '0, pc_nx = '0, flush_tgt = '0, orphan_addr = '0;
  logic ack_hold = 1'b0, orphan = 1'b0;
  int tests = 0, fails = 0, delay = 0, wcnt = 0;
  logic [INSN_W+ADDR_W-1:0] sb[$];
  logic [INSN_W+ADDR_W-1:0] head;
  if_fetch_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) bus ();
`ifdef IF_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  if_fetch #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) dut (
    .clk(clk),
    .rst(rst),
    .pc_i(pc_i),
    .pc_adv(pc_adv),
    .flush(flush),
    .bus(bus)
`ifdef IF_FETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] insn_of(input logic [16:0] a);
    return {a[14:0], a} ^ 32'hA5C3_0F96;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic look;
    @(negedge clk);
    #2;
  endtask
  task automatic do_reset(input int d, input logic r);
    rst = 1'b1;
    flush = 1'b0;
    ack_hold = 1'b0;
    delay = d;
    bus.id_ready = r;
    tick;
    tick;
    rst = 1'b0;
  endtask
  // memory: acks after 'delay' waiting cycles unless held off
  always @(negedge clk) begin
    bus.imem_ack = bus.imem_req && !ack_hold && wcnt >= delay;
    bus.imem_rdata = insn_of(bus.imem_addr);
    wcnt = (rst || !bus.imem_req || bus.imem_ack) ? 0 : wcnt + 1;
  end
  // scoreboard and pc model
  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb.delete();
      orphan = 1'b0;
      pc_nx = '0;
    end else begin
      if (bus.id_valid) begin
        if (sb.size() == 0) check("id_valid_empty", bus.id_valid, 0);
        else begin
          head = sb[0];
          check("id_pc", bus.id_pc, head[ADDR_W-1:0]);
          check("id_insn", bus.id_insn, head[INSN_W+ADDR_W-1:ADDR_W]);
          if (bus.id_ready && !flush) void'(sb.pop_front());
        end
      end
      if (flush) begin
        sb.delete();
        check("pc_adv_flush", pc_adv, 0);
      end
      if (bus.imem_req && bus.imem_ack) begin
        if (orphan) begin
          check("drop_addr", bus.imem_addr, orphan_addr);
          orphan = 1'b0;
        end else if (!flush) begin
          check("req_addr", bus.imem_addr, pc_i);
          check("pc_adv_ack", pc_adv, 1);
          sb.push_back({insn_of(pc_i), pc_i});
        end
      end else begin
        check("pc_adv_noack", pc_adv, 0);
        if (flush && bus.imem_req && !orphan) begin
          orphan = 1'b1;
          orphan_addr = bus.imem_addr;
        end
      end
      pc_nx = flush ? flush_tgt : pc_adv ? pc_i + 17'd1 : pc_i;
    end
  end
  always @(posedge clk) begin
    #1;
    pc_i = pc_nx;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, k;
    bus.id_ready = 1'b1;
    // streaming with zero-wait memory
    do_reset(0, 1'b1);
    look;
    check("rst_req", bus.imem_req, 0);
    check("rst_valid", bus.id_valid, 0);
    check("rst_adv", pc_adv, 0);
`ifdef IF_FETCH_STALL_CNT_EN
    check("rst_stall", stall_cnt, 0);
`endif
    tick; look;
    check("c2_req", bus.imem_req, 1);
    check("c2_addr", bus.imem_addr, 0);
    check("c2_adv", pc_adv, 1);
    for (int i = 0; i < 5; i++) begin
      tick; look;
      check("stream_valid", bus.id_valid, 1);
      check("stream_pc", bus.id_pc, i);
      check("stream_adv", pc_adv, 1);
    end
    // decode stalled: FIFO fills, requests stop, nothing lost
    do_reset(0, 1'b0);
    n = 0;
    look;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin tick; look; end
      if (bus.imem_req && bus.imem_ack) n++;
    end
    check("full_reads", n, 2);
    check("full_req", bus.imem_req, 0);
    check("full_pc", pc_i, 2);
    tick; bus.id_ready = 1'b1; look;
    check("drain0_pc", bus.id_pc, 0);
    check("drain0_bubble", bus.imem_req, 0);
    tick; look;
    check("drain1_pc", bus.id_pc, 1);
    tick; look;
    check("drain2_pc", bus.id_pc, 2);
    // slow memory: request held stable until ack
    do_reset(3, 1'b1);
    k = 0;
    look;
    for (int i = 0; i < 16; i++) begin
      tick; look;
      check("dly_req", bus.imem_req, 1);
      check("dly_addr", bus.imem_addr, k);
      check("dly_adv", pc_adv, bus.imem_ack);
      if (bus.imem_ack) k++;
    end
    check("dly_count", k, 4);
    // flush orphans a pending request to 5
    do_reset(0, 1'b1);
    look;
    for (int i = 2; i <= 6; i++) begin tick; look; end
    tick; ack_hold = 1'b1; look;
    check("fl_pend_addr", bus.imem_addr, 17'h00005);
    check("fl_pend_ack", bus.imem_ack, 0);
    tick; flush = 1'b1; flush_tgt = 17'h00100; look;
    check("fl_adv", pc_adv, 0);
    tick; flush = 1'b0; look;
    check("drop_req", bus.imem_req, 1);
    check("drop_addr1", bus.imem_addr, 17'h00005);
    check("drop_valid", bus.id_valid, 0);
    tick; ack_hold = 1'b0; look;
    check("drop_addr2", bus.imem_addr, 17'h00005);
    check("drop_ack", bus.imem_ack, 1);
    check("drop_adv", pc_adv, 0);
    tick; look;
    check("redir_addr", bus.imem_addr, 17'h00100);
    tick; look;
    check("redir_valid", bus.id_valid, 1);
    check("redir_pc", bus.id_pc, 17'h00100);
    // flush coinciding with ack and pop
    do_reset(0, 1'b1);
    look;
    for (int i = 2; i <= 5; i++) begin tick; look; end
    tick; flush = 1'b1; flush_tgt = 17'h00200; look;
    check("fa_valid", bus.id_valid, 1);
    check("fa_pc", bus.id_pc, 3);
    check("fa_ack", bus.imem_ack, 1);
    check("fa_adv", pc_adv, 0);
    tick; flush = 1'b0; look;
    check("fa_killed", bus.id_valid, 0);
    check("fa_addr", bus.imem_addr, 17'h00200);
    tick; look;
    check("fa_next_pc", bus.id_pc, 17'h00200);
`ifdef IF_FETCH_STALL_CNT_EN
    // decode starved by a memory that ignores the first requests
    do_reset(0, 1'b1);
    ack_hold = 1'b1;
    look;
    for (int i = 2; i <= 9; i++) begin tick; look; end
    check("st_valid", bus.id_valid, 0);
    tick; ack_hold = 1'b0; look;
    check("st_ack", bus.imem_ack, 1);
    tick; look;
    check("st_first", bus.id_valid, 1);
    check("st_cnt", stall_cnt, 9);
    tick; look;
    check("st_hold", stall_cnt, 9);
`endif
    for (int i = 0; i < 4; i++) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
